// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave fronting a 32 x 8-bit register file, using the 24L01 command format.
// SPI pins are oversampled on CLK; the local side gets a registered read/write port.
module spi_slave_regfile #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       SPI_CSN,
  input  logic       SPI_CLK,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       SPI_MISO_OE,
  input  logic [7:0] STATUS,
  input  logic       Loc_WR_En,
  input  logic [4:0] Loc_Addr,
  input  logic [7:0] Loc_WDat,
  output logic [7:0] Loc_RDat,
  output logic       Wr_Strobe,
  output logic [4:0] Wr_Addr,
  output logic [7:0] Wr_Dat,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic                   sck_d, csn_d;
  logic                   sck_s, csn_s, mosi_s;
  logic                   sck_rise, sck_fall, csn_fall, csn_rise;
  logic                   byte_full, byte_end, spi_commit;
  logic [3:0]             bit_cnt;
  logic [6:0]             rx_sh, tx_sh;
  logic [7:0]             rx_byte, tx_load;
  logic [4:0]             addr;
  logic                   is_read, is_write;
  logic [7:0]             regs [32];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_CLK};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], SPI_CSN};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      csn_d     <= csn_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csn_fall = ~csn_s & csn_d;
  assign csn_rise = csn_s & ~csn_d;

  assign rx_byte    = {rx_sh, mosi_s};
  assign byte_full  = sck_rise && (bit_cnt == 4'd7);
  assign byte_end   = sck_fall && (bit_cnt == 4'd8);
  assign spi_commit = (state == DATA) && !csn_rise && byte_full && is_write;
  assign tx_load    = is_read ? regs[addr] : 8'h00;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csn_fall) state_nxt = CMD;
      CMD:     if (csn_rise) state_nxt = IDLE;
               else if (byte_end) state_nxt = DATA;
      DATA:    if (csn_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy        = 1'b0;
    SPI_MISO_OE = 1'b0;
    if (state != IDLE) begin
      Busy        = 1'b1;
      SPI_MISO_OE = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      SPI_MISO <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      bit_cnt  <= '0;
      addr     <= '0;
      is_read  <= 1'b0;
      is_write <= 1'b0;
    end else if (state == IDLE) begin
      if (csn_fall) begin
        tx_sh    <= STATUS[6:0];
        SPI_MISO <= STATUS[7];
        bit_cnt  <= '0;
        is_read  <= 1'b0;
        is_write <= 1'b0;
      end
    end else if (csn_rise) begin
      SPI_MISO <= 1'b0;
      bit_cnt  <= '0;
    end else if (sck_rise) begin
      rx_sh   <= rx_byte[6:0];
      bit_cnt <= bit_cnt + 4'd1;
      if (bit_cnt == 4'd7) begin
        if (state == CMD) begin
          is_read  <= (rx_byte[7:5] == 3'b000);
          is_write <= (rx_byte[7:5] == 3'b001);
          addr     <= rx_byte[4:0];
        end else begin
          addr <= addr + 5'd1;
        end
      end
    end else if (sck_fall) begin
      // Falls 1..7 shift out the current byte; the fall after the 8th rise starts the next one.
      if (bit_cnt == 4'd8) begin
        bit_cnt  <= '0;
        tx_sh    <= tx_load[6:0];
        SPI_MISO <= tx_load[7];
      end else begin
        tx_sh    <= {tx_sh[5:0], 1'b0};
        SPI_MISO <= tx_sh[6];
      end
    end
  end

  // NOTE: the register file is reset explicitly because software expects all registers to read 0.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      Loc_RDat  <= '0;
      Wr_Strobe <= 1'b0;
      Wr_Addr   <= '0;
      Wr_Dat    <= '0;
    end else begin
      Loc_RDat  <= regs[Loc_Addr];
      Wr_Strobe <= spi_commit;
      if (Loc_WR_En) regs[Loc_Addr] <= Loc_WDat;
      // Placed after the local write so an SPI commit to the same address wins.
      if (spi_commit) begin
        regs[addr] <= rx_byte;
        Wr_Addr    <= addr;
        Wr_Dat     <= rx_byte;
      end
    end
  end

endmodule
